// File: rtl/mem_port_defs_pkg.sv
// Shared encodings, widths and request payload for the memory port responder.
package mem_port_defs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    // Access size encodings on req_size.
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Responder FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Request captured at accept and held until the response is produced.
    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Reserved size, odd half address or non word-aligned word address.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_WORD: bad = (addr_lo != 2'b00);
            SIZE_HALF: bad = addr_lo[0];
            SIZE_BYTE: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Big-endian lane steering: merges store data into a word and extracts load lanes.
module mem_lane_merge
    import mem_port_defs_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] merged_word_c,
    output logic [DATA_W-1:0] rd_lane_c,
    output logic              misalign_c
);

    // Byte 0 / half 0 live in the most significant lanes of the word.
    always_comb begin
        merged_word_c = old_word;
        rd_lane_c     = '0;
        case (size)
            SIZE_WORD: begin
                merged_word_c = wdata;
                rd_lane_c     = old_word;
            end
            SIZE_HALF: begin
                if (addr_lo[1]) begin
                    merged_word_c[15:0] = wdata[15:0];
                    rd_lane_c           = {16'b0, old_word[15:0]};
                end else begin
                    merged_word_c[31:16] = wdata[15:0];
                    rd_lane_c            = {16'b0, old_word[31:16]};
                end
            end
            SIZE_BYTE: begin
                case (addr_lo)
                    2'd0: begin
                        merged_word_c[31:24] = wdata[7:0];
                        rd_lane_c            = {24'b0, old_word[31:24]};
                    end
                    2'd1: begin
                        merged_word_c[23:16] = wdata[7:0];
                        rd_lane_c            = {24'b0, old_word[23:16]};
                    end
                    2'd2: begin
                        merged_word_c[15:8] = wdata[7:0];
                        rd_lane_c           = {24'b0, old_word[15:8]};
                    end
                    default: begin
                        merged_word_c[7:0] = wdata[7:0];
                        rd_lane_c          = {24'b0, old_word[7:0]};
                    end
                endcase
            end
            default: begin
                merged_word_c = old_word;
                rd_lane_c     = '0;
            end
        endcase
    end

    assign misalign_c = misaligned(size, addr_lo);

endmodule

// File: rtl/mem_port_responder.sv
// Single-outstanding memory responder: fixed latency, in-edge read-modify-write for narrow stores.
module mem_port_responder
    import mem_port_defs_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned WORDS = 2 ** IDX_W;

    logic [1:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              ready_n, valid_n, err_n;
    logic [DATA_W-1:0] rdata_n;
    mem_req_t          req_q;

    logic [DATA_W-1:0] mem [WORDS];

    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] old_word_c;
    logic [DATA_W-1:0] merged_word_c;
    logic [DATA_W-1:0] rd_lane_c;
    logic              misalign_c;
    logic              finish_c;
    logic              commit_c;
    logic              unused_addr_bits;

    // Address bits above the decoded range wrap onto the same storage.
    assign idx_c            = req_q.addr[ADDR_W-1:2];
    assign unused_addr_bits = ^req_q.addr[DATA_W-1:ADDR_W];
    assign old_word_c       = mem[idx_c];

    // Last WAIT cycle: the next edge samples/commits storage and enters RESP.
    assign finish_c = (state == ST_WAIT) && (cnt == CNT_W'(1));
    assign commit_c = finish_c && req_q.we && !misalign_c;

    mem_lane_merge u_lane_merge (
        .old_word      (old_word_c),
        .wdata         (req_q.wdata),
        .size          (req_q.size),
        .addr_lo       (req_q.addr[1:0]),
        .merged_word_c (merged_word_c),
        .rd_lane_c     (rd_lane_c),
        .misalign_c    (misalign_c)
    );

    // Next state, latency count and next values of the registered outputs.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ready_n = 1'b0;
        valid_n = 1'b0;
        rdata_n = '0;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_n = ST_WAIT;
                    cnt_n   = CNT_W'(LATENCY);
                end else begin
                    ready_n = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (finish_c) begin
                    state_n = ST_RESP;
                    valid_n = 1'b1;
                    err_n   = misalign_c;
                    rdata_n = (req_q.we || misalign_c) ? '0 : rd_lane_c;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    // State, counter and response registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            req_ready <= ready_n;
            rsp_valid <= valid_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
        end
    end

    // Request latch, loaded only when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q <= '0;
        end else if ((state == ST_IDLE) && req_valid) begin
            req_q <= '{we: req_we, size: req_size, addr: req_addr, wdata: req_wdata};
        end
    end

    // Word storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem[idx_c] <= merged_word_c;
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench: two responders (LATENCY 1 and 4) share stimulus and are checked against a
// transaction-level model every cycle, plus literal expectations per transaction.
module tb_mem_port_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_responder #(
            .ADDR_W  (8),
            .LATENCY ((g == 0) ? 1 : 4)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid),
            .req_ready (req_ready[g]),
            .req_we    (req_we),
            .req_size  (req_size),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic void chk(input string name, input int i, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    bit          m_ready [2] = '{1'b1, 1'b1};
    bit          m_valid [2];
    logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
    bit          m_err   [2];
    bit          m_busy  [2];
    int          m_due   [2];
    bit          p_we    [2];
    logic [1:0]  p_size  [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [31:0] m_mem   [2][64];
    int          cyc = 0;

    // Perform the pending access of model i: big-endian lane mask/shift arithmetic.
    function automatic void model_exec(input int i);
        int          a, idx, sh;
        logic [31:0] w, mask;
        bit          bad;
        a    = int'(p_addr[i][1:0]);
        idx  = int'(p_addr[i][7:2]);
        w    = m_mem[i][idx];
        bad  = (p_size[i] == 2'd3) || (p_size[i] == 2'd1 && (a % 2) == 1) ||
               (p_size[i] == 2'd0 && a != 0);
        m_valid[i] = 1'b1;
        m_rdata[i] = 32'h0;
        m_err[i]   = bad;
        if (bad) return;
        if (p_size[i] == 2'd0) begin
            sh = 0;  mask = 32'hFFFF_FFFF;
        end else if (p_size[i] == 2'd1) begin
            sh = (a >= 2) ? 0 : 16;  mask = 32'h0000_FFFF << sh;
        end else begin
            sh = 8 * (3 - a);  mask = 32'h0000_00FF << sh;
        end
        if (p_we[i]) m_mem[i][idx] = (w & ~mask) | ((p_wdata[i] << sh) & mask);
        else         m_rdata[i]    = (w & mask) >> sh;
    endfunction

    // Response due LATENCY edges after accept; idle again one edge after the response.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_ready[i] = 1'b1; m_valid[i] = 1'b0; m_rdata[i] = 32'h0;
                m_err[i] = 1'b0; m_busy[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_valid[i]) begin
                    m_valid[i] = 1'b0; m_rdata[i] = 32'h0; m_err[i] = 1'b0; m_ready[i] = 1'b1;
                end else if (m_busy[i]) begin
                    if (cyc == m_due[i]) begin
                        m_busy[i] = 1'b0;
                        model_exec(i);
                    end
                end else if (req_valid) begin
                    m_busy[i] = 1'b1; m_ready[i] = 1'b0; m_due[i] = cyc + lat_of(i);
                    p_we[i] = req_we; p_size[i] = req_size;
                    p_addr[i] = req_addr; p_wdata[i] = req_wdata;
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("cyc_ready", i, 32'(req_ready[i]), 32'(m_ready[i]));
                chk("cyc_valid", i, 32'(rsp_valid[i]), 32'(m_valid[i]));
                chk("cyc_rdata", i, rsp_rdata[i], m_rdata[i]);
                chk("cyc_err",   i, 32'(rsp_err[i]), 32'(m_err[i]));
            end
        end
    end

    // Response capture for the held-valid test.
    logic [32:0] rsp_q0 [$];
    logic [32:0] rsp_q1 [$];
    always @(negedge clk) begin
        if (reset && rsp_valid[0]) rsp_q0.push_back({rsp_err[0], rsp_rdata[0]});
        if (reset && rsp_valid[1]) rsp_q1.push_back({rsp_err[1], rsp_rdata[1]});
    end

    // One request to both responders; checks latency and literal response values.
    task automatic txn(input bit we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
        int          lat [2];
        logic [31:0] rd  [2];
        logic        er  [2];
        lat = '{-1, -1};
        rd  = '{32'hx, 32'hx};
        er  = '{1'bx, 1'bx};
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            if (n == 0) req_valid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (lat[i] < 0 && rsp_valid[i]) begin
                    lat[i] = n; rd[i] = rsp_rdata[i]; er[i] = rsp_err[i];
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("latency", i, 32'(lat[i]), 32'(lat_of(i)));
            chk("rsp_rdata", i, rd[i], exp_rd);
            chk("rsp_err", i, 32'(er[i]), 32'(exp_err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++) m_mem[i][j] = 32'h0;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(req_ready[i]), 32'd1);
            chk("rst_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("rst_rdata", i, rsp_rdata[i], 32'd0);
            chk("rst_err",   i, 32'(rsp_err[i]), 32'd0);
        end
        reset = 1'b1;
        #1 chk_en = 1'b1;

        // Word write/read, then narrow RMW and lane extraction.
        txn(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn(1'b0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 2'd2, 32'h11, 32'h55, 32'h0, 1'b0);
        txn(1'b0, 2'd0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0);
        txn(1'b0, 2'd1, 32'h12, 32'h0, 32'h0000BEEF, 1'b0);
        txn(1'b0, 2'd2, 32'h11, 32'h0, 32'h00000055, 1'b0);

        // Errors: misaligned half store, misaligned word load, reserved size.
        txn(1'b1, 2'd1, 32'h13, 32'h1234, 32'h0, 1'b1);
        txn(1'b0, 2'd0, 32'h22, 32'h0, 32'h0, 1'b1);
        txn(1'b0, 2'd3, 32'h10, 32'h0, 32'h0, 1'b1);
        txn(1'b0, 2'd0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0);

        // Write to aliased address aborted by reset during WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
        req_addr = 32'h110; req_wdata = 32'h11112222;
        @(posedge clk);
        #2 req_valid = 1'b0; reset = 1'b0;
        #2 reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk("abort_no_rsp", i, 32'(rsp_valid[i]), 32'd0);
        end
        txn(1'b0, 2'd0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0);

        // Completed aliased write, then byte/half accesses on it.
        txn(1'b1, 2'd0, 32'h110, 32'hCAFEF00D, 32'h0, 1'b0);
        txn(1'b0, 2'd0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        txn(1'b0, 2'd2, 32'h13, 32'h0, 32'h0000000D, 1'b0);
        txn(1'b0, 2'd2, 32'h10, 32'h0, 32'h000000CA, 1'b0);
        txn(1'b1, 2'd1, 32'h10, 32'hFFFFABCD, 32'h0, 1'b0);
        txn(1'b0, 2'd0, 32'h10, 32'h0, 32'hABCDF00D, 1'b0);

        // Asynchronous reset while the LATENCY=1 responder is presenting a response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk) req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_async_valid", 0, 32'(rsp_valid[0]), 32'd1);
        chk("pre_async_rdata", 0, rsp_rdata[0], 32'hABCDF00D);
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_ready", i, 32'(req_ready[i]), 32'd1);
            chk("async_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("async_rdata", i, rsp_rdata[i], 32'd0);
        end
        #1 reset = 1'b1;
        repeat (8) @(negedge clk);

        // req_valid held high with a changing address: only idle-state requests are served.
        for (int j = 0; j < 4; j++)
            txn(1'b1, 2'd0, 32'h20 + 32'(4 * j), 32'h1000_0000 | 32'(j), 32'h0, 1'b0);
        rsp_q0.delete();
        rsp_q1.delete();
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0;
            req_addr = 32'h20 + 32'(4 * (j % 4));
        end
        @(negedge clk) req_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_count", 0, 32'(rsp_q0.size()), 32'd5);
        chk("held_count", 1, 32'(rsp_q1.size()), 32'd3);
        chk("held_first", 0, (rsp_q0.size() > 0) ? rsp_q0[0][31:0] : 32'hFFFF_FFFF, 32'h1000_0000);
        chk("held_second", 0, (rsp_q0.size() > 1) ? rsp_q0[1][31:0] : 32'hFFFF_FFFF, 32'h1000_0003);
        chk("held_second", 1, (rsp_q1.size() > 1) ? rsp_q1[1][31:0] : 32'hFFFF_FFFF, 32'h1000_0002);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
